// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32 memory stage: result-select codes, access
// size codes, and the bus FSM state type.
package rv32_mem_pkg;

  // Writeback result select
  localparam logic [2:0] RS_ALU  = 3'b000;
  localparam logic [2:0] RS_MEM  = 3'b001;
  localparam logic [2:0] RS_PC4  = 3'b010;
  localparam logic [2:0] RS_IMM  = 3'b011;
  localparam logic [2:0] RS_PCT  = 3'b100;

  // Access size / sign (funct3)
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  // Data bus FSM, 2-bit encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Unsigned sizes exist only for loads; anything else is illegal.
  function automatic logic size_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: size_legal = 1'b1;
      F3_BU, F3_HU:     size_legal = ~we;
      default:          size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by low address bits
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by size/sign; illegal codes never reach writeback, pass the word
  always_comb begin
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'd0, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'd0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32 memory stage: issues loads/stores on a valid/ready data bus, stalls
// the upstream pipeline until the access completes, aligns load data and
// registers the selected result into the MEM/WB stage.
module mem_stage_lsu
  import rv32_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] M_ALUResult,
  input  logic [DATA_WIDTH-1:0] M_WriteData,
  input  logic [DATA_WIDTH-1:0] M_ImmExt,
  input  logic [DATA_WIDTH-1:0] M_PCPlus4,
  input  logic [DATA_WIDTH-1:0] M_PCTarget,
  input  logic [4:0]            M_Rd,
  input  logic [2:0]            M_ResultSrc,
  input  logic [2:0]            M_Funct3,
  input  logic                  M_RegWrite,
  input  logic                  M_MemWrite,
  output logic                  dbus_req_valid,
  input  logic                  dbus_req_ready,
  output logic                  dbus_req_we,
  output logic [ADDR_WIDTH-1:0] dbus_req_addr,
  output logic [DATA_WIDTH-1:0] dbus_req_wdata,
  output logic [3:0]            dbus_req_wstrb,
  input  logic                  dbus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dbus_rsp_rdata,
  input  logic                  dbus_rsp_err,
  output logic                  mem_stall,
  output logic                  mem_misalign,
  output logic                  mem_buserr,
  output logic [DATA_WIDTH-1:0] W_Result,
  output logic [4:0]            W_Rd,
  output logic                  W_RegWrite
);

  mem_state_e            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_load, access, misalign;
  logic                  rsp_done, err;
  logic [DATA_WIDTH-1:0] load_val, result;

  assign addr     = M_ALUResult[ADDR_WIDTH-1:0];
  assign is_load  = (M_ResultSrc == RS_MEM);
  assign access   = M_MemWrite | is_load;
  assign misalign = access & (~size_legal(M_Funct3, M_MemWrite)
                           | ((M_Funct3[1:0] == 2'b01) & addr[0])
                           | ((M_Funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));

  // Responses only count while waiting for one; stray ones are dropped
  assign rsp_done = (state == ST_WAIT) & dbus_rsp_valid;
  assign err      = rsp_done & dbus_rsp_err;

  assign mem_misalign  = (state == ST_IDLE) & misalign;
  assign mem_buserr    = err;
  assign dbus_req_we   = M_MemWrite;
  assign dbus_req_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

  // Request/stall: request goes out combinationally from IDLE so a ready
  // slave can accept in the same cycle the instruction arrives
  always_comb begin
    dbus_req_valid = 1'b0;
    mem_stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        dbus_req_valid = access & ~misalign;
        mem_stall      = access & ~misalign;
      end
      ST_REQ: begin
        dbus_req_valid = 1'b1;
        mem_stall      = 1'b1;
      end
      ST_WAIT:  mem_stall = ~dbus_rsp_valid;
      default: ;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    dbus_req_wstrb = 4'b0000;
    dbus_req_wdata = M_WriteData;
    case (M_Funct3[1:0])
      2'b00: begin
        dbus_req_wstrb = 4'b0001 << addr[1:0];
        dbus_req_wdata = {4{M_WriteData[7:0]}};
      end
      2'b01: begin
        dbus_req_wstrb = 4'b0011 << {addr[1], 1'b0};
        dbus_req_wdata = {2{M_WriteData[15:0]}};
      end
      default: dbus_req_wstrb = 4'b1111;
    endcase
    if (!M_MemWrite) dbus_req_wstrb = 4'b0000;
  end

  load_align u_load_align (
    .rdata   (dbus_rsp_rdata),
    .addr_lo (addr[1:0]),
    .funct3  (M_Funct3),
    .value   (load_val)
  );

  // Writeback source mux; unused codes fall back to the ALU result
  always_comb begin
    case (M_ResultSrc)
      RS_MEM:  result = load_val;
      RS_PC4:  result = M_PCPlus4;
      RS_IMM:  result = M_ImmExt;
      RS_PCT:  result = M_PCTarget;
      default: result = M_ALUResult;
    endcase
  end

  // Bus FSM: IDLE issues, REQ holds until accepted, WAIT until response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (dbus_req_valid) state <= dbus_req_ready ? ST_WAIT : ST_REQ;
        ST_REQ:  if (dbus_req_ready) state <= ST_WAIT;
        ST_WAIT: if (dbus_rsp_valid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_Result   <= '0;
      W_Rd       <= '0;
      W_RegWrite <= 1'b0;
    end else if (!mem_stall) begin
      W_Result   <= result;
      W_Rd       <= M_Rd;
      W_RegWrite <= M_RegWrite & ~misalign & ~err;
    end else begin
      W_RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads/stores with bus latency, alignment,
// misalign/bus-error handling, non-memory writeback and mid-transaction reset.
module tb_mem_stage_lsu;

  logic        clk, rst_n;
  logic [31:0] M_ALUResult, M_WriteData, M_ImmExt, M_PCPlus4, M_PCTarget;
  logic [4:0]  M_Rd;
  logic [2:0]  M_ResultSrc, M_Funct3;
  logic        M_RegWrite, M_MemWrite;
  logic        dbus_req_valid, dbus_req_ready, dbus_req_we;
  logic [31:0] dbus_req_addr, dbus_req_wdata;
  logic [3:0]  dbus_req_wstrb;
  logic        dbus_rsp_valid, dbus_rsp_err;
  logic [31:0] dbus_rsp_rdata;
  logic        mem_stall, mem_misalign, mem_buserr;
  logic [31:0] W_Result;
  logic [4:0]  W_Rd;
  logic        W_RegWrite;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_ALUResult(M_ALUResult), .M_WriteData(M_WriteData), .M_ImmExt(M_ImmExt),
    .M_PCPlus4(M_PCPlus4), .M_PCTarget(M_PCTarget), .M_Rd(M_Rd),
    .M_ResultSrc(M_ResultSrc), .M_Funct3(M_Funct3),
    .M_RegWrite(M_RegWrite), .M_MemWrite(M_MemWrite),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_req_we(dbus_req_we), .dbus_req_addr(dbus_req_addr),
    .dbus_req_wdata(dbus_req_wdata), .dbus_req_wstrb(dbus_req_wstrb),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_rdata(dbus_rsp_rdata),
    .dbus_rsp_err(dbus_rsp_err),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_buserr(mem_buserr),
    .W_Result(W_Result), .W_Rd(W_Rd), .W_RegWrite(W_RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    M_ALUResult = 32'h0; M_WriteData = 32'h0; M_ImmExt = 32'h0;
    M_PCPlus4 = 32'h0; M_PCTarget = 32'h0; M_Rd = 5'd0;
    M_ResultSrc = 3'b000; M_Funct3 = 3'b000; M_RegWrite = 1'b0; M_MemWrite = 1'b0;
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_err = 1'b0; dbus_rsp_rdata = 32'h0;
  endtask

  task automatic set_op(input logic [2:0] rs, input logic [2:0] f3, input logic we,
                        input logic rw, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] wd);
    M_ResultSrc = rs; M_Funct3 = f3; M_MemWrite = we; M_RegWrite = rw;
    M_Rd = rd; M_ALUResult = a; M_WriteData = wd;
  endtask

  // Bus slave for one access: ready after ready_lat cycles, response rsp_lat
  // cycles after acceptance. Returns what was observed on the way.
  task automatic mem_op(input logic [31:0] rdata, input logic err,
                        input int ready_lat, input int rsp_lat,
                        output int nv, output int ns, output int nbe,
                        output logic [3:0] strb, output logic [31:0] wd,
                        output logic [31:0] ad, output bit done);
    int c;
    int acc;
    c = 0; acc = -1; done = 0; nv = 0; ns = 0; nbe = 0;
    strb = 4'hx; wd = 32'hx; ad = 32'hx;
    while (!done && c < 50) begin
      dbus_req_ready = (acc < 0) && (c >= ready_lat);
      dbus_rsp_valid = (acc >= 0) && (c == acc + rsp_lat);
      dbus_rsp_rdata = dbus_rsp_valid ? rdata : 32'h0;
      dbus_rsp_err   = dbus_rsp_valid & err;
      #1;
      if (dbus_req_valid) begin
        nv++; strb = dbus_req_wstrb; wd = dbus_req_wdata; ad = dbus_req_addr;
      end
      if (mem_stall) ns++;
      if (mem_buserr) nbe++;
      if (dbus_rsp_valid) done = 1;
      if (dbus_req_valid && dbus_req_ready) acc = c;
      step();
      c++;
    end
    set_nop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_nop();
    step(); step();
    n_checks++;
    if (W_Result !== 32'h0 || W_Rd !== 5'd0 || W_RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_w: got %h/%0d/%b want 0/0/0", W_Result, W_Rd, W_RegWrite);
    end
    n_checks++;
    if (mem_stall !== 1'b0 || mem_misalign !== 1'b0 || mem_buserr !== 1'b0 || dbus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: stall %b mis %b berr %b vld %b want 0", mem_stall, mem_misalign, mem_buserr, dbus_req_valid);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0);
    mem_op(32'hDEADBEEF, 1'b0, 0, 3, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL lw_timeout: no response completed"); end
    n_checks++;
    if (ns != 3 || nv != 1) begin n_fail++; $display("FAIL lw_stall: stall %0d valid %0d want 3 1", ns, nv); end
    n_checks++;
    if (ad !== 32'h100 || st !== 4'b0000) begin n_fail++; $display("FAIL lw_req: addr %h strb %b want 00000100 0000", ad, st); end
    n_checks++;
    if (W_Result !== 32'hDEADBEEF || W_RegWrite !== 1'b1 || W_Rd !== 5'd5) begin
      n_fail++; $display("FAIL lw_wb: %h/%b/%0d want deadbeef/1/5", W_Result, W_RegWrite, W_Rd);
    end
    step();
    n_checks++;
    if (W_RegWrite !== 1'b0) begin n_fail++; $display("FAIL lw_after: W_RegWrite %b want 0", W_RegWrite); end
  endtask

  task automatic test_load_ext();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a  [4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exp[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
    for (int i = 0; i < 4; i++) begin
      set_op(3'b001, f3[i], 1'b0, 1'b1, 5'd9, a[i], 32'h0);
      mem_op(32'h80112233, 1'b0, 0, 1, nv, ns, nbe, st, wd, ad, ok);
      n_checks++;
      if (!ok || W_Result !== exp[i] || W_RegWrite !== 1'b1) begin
        n_fail++; $display("FAIL load_ext[%0d]: got %h/%b want %h/1", i, W_Result, W_RegWrite, exp[i]);
      end
      n_checks++;
      if (ns != 1) begin n_fail++; $display("FAIL load_ext_stall[%0d]: %0d want 1", i, ns); end
    end
  endtask

  task automatic test_store();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    set_op(3'b000, 3'b001, 1'b1, 1'b0, 5'd0, 32'h202, 32'h0000ABCD);
    mem_op(32'h0, 1'b0, 2, 1, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || nv != 3 || ns != 3) begin n_fail++; $display("FAIL sh_hold: valid %0d stall %0d want 3 3", nv, ns); end
    n_checks++;
    if (st !== 4'b1100 || wd !== 32'hABCDABCD || ad !== 32'h200) begin
      n_fail++; $display("FAIL sh_bus: strb %b wdata %h addr %h want 1100 abcdabcd 00000200", st, wd, ad);
    end
    n_checks++;
    if (W_RegWrite !== 1'b0) begin n_fail++; $display("FAIL sh_wb: W_RegWrite %b want 0", W_RegWrite); end
    set_op(3'b000, 3'b000, 1'b1, 1'b0, 5'd0, 32'h201, 32'h1234565A);
    mem_op(32'h0, 1'b0, 0, 1, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || st !== 4'b0010 || wd !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL sb_bus: strb %b wdata %h want 0010 5a5a5a5a", st, wd);
    end
    set_op(3'b000, 3'b010, 1'b1, 1'b0, 5'd0, 32'h300, 32'hCAFEF00D);
    mem_op(32'h0, 1'b0, 0, 1, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || st !== 4'b1111 || wd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL sw_bus: strb %b wdata %h want 1111 cafef00d", st, wd);
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] a  [3] = '{32'h101, 32'h103, 32'h100};
    for (int i = 0; i < 3; i++) begin
      set_op(3'b001, f3[i], 1'b0, 1'b1, 5'd3, a[i], 32'h0);
      #1;
      n_checks++;
      if (dbus_req_valid !== 1'b0 || mem_misalign !== 1'b1 || mem_stall !== 1'b0) begin
        n_fail++; $display("FAIL misalign[%0d]: vld %b mis %b stall %b want 0 1 0", i, dbus_req_valid, mem_misalign, mem_stall);
      end
      step();
      n_checks++;
      if (W_RegWrite !== 1'b0) begin n_fail++; $display("FAIL misalign_wb[%0d]: %b want 0", i, W_RegWrite); end
      set_nop();
      #1;
      n_checks++;
      if (mem_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse[%0d]: %b want 0", i, mem_misalign); end
      step();
    end
  endtask

  task automatic test_buserr_and_alu();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    logic [2:0]  rs [4] = '{3'b010, 3'b011, 3'b100, 3'b110};
    logic [31:0] exp[4] = '{32'h44, 32'h12345000, 32'h00001008, 32'h0000BEEF};
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd6, 32'h140, 32'h0);
    mem_op(32'h11111111, 1'b1, 0, 2, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || nbe != 1 || W_RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL buserr: pulses %0d W_RegWrite %b want 1 0", nbe, W_RegWrite);
    end
    for (int i = 0; i < 4; i++) begin
      set_op(rs[i], 3'b000, 1'b0, 1'b1, 5'd7, 32'h0000BEEF, 32'h0);
      M_PCPlus4 = 32'h44; M_ImmExt = 32'h12345000; M_PCTarget = 32'h00001008;
      #1;
      n_checks++;
      if (mem_stall !== 1'b0 || dbus_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL alu_nostall[%0d]: stall %b vld %b want 0 0", i, mem_stall, dbus_req_valid);
      end
      step();
      n_checks++;
      if (W_Result !== exp[i] || W_RegWrite !== 1'b1 || W_Rd !== 5'd7) begin
        n_fail++; $display("FAIL result_mux[%0d]: %h/%b/%0d want %h/1/7", i, W_Result, W_RegWrite, W_Rd, exp[i]);
      end
    end
    set_nop();
  endtask

  task automatic test_back_to_back();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd10, 32'h400, 32'h0);
    mem_op(32'hA5A5A5A5, 1'b0, 0, 1, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || W_Result !== 32'hA5A5A5A5 || W_Rd !== 5'd10) begin
      n_fail++; $display("FAIL b2b_first: %h/%0d want a5a5a5a5/10", W_Result, W_Rd);
    end
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd11, 32'h404, 32'h0);
    #1;
    n_checks++;
    if (dbus_req_valid !== 1'b1 || dbus_req_addr !== 32'h404) begin
      n_fail++; $display("FAIL b2b_issue: vld %b addr %h want 1 00000404", dbus_req_valid, dbus_req_addr);
    end
    mem_op(32'h5A5A5A5A, 1'b0, 0, 1, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || W_Result !== 32'h5A5A5A5A || W_Rd !== 5'd11 || ns != 1) begin
      n_fail++; $display("FAIL b2b_second: %h/%0d stall %0d want 5a5a5a5a/11 1", W_Result, W_Rd, ns);
    end
  endtask

  task automatic test_reset_mid();
    int nv, ns, nbe; logic [3:0] st; logic [31:0] wd, ad; bit ok;
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd12, 32'h500, 32'h0);
    dbus_req_ready = 1'b1;
    step();
    dbus_req_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_stall !== 1'b1 || dbus_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_state: stall %b vld %b want 1 0", mem_stall, dbus_req_valid);
    end
    rst_n = 1'b0;
    set_nop();
    #1;
    n_checks++;
    if (W_Result !== 32'h0 || W_Rd !== 5'd0 || W_RegWrite !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: %h/%0d/%b stall %b want 0/0/0 0", W_Result, W_Rd, W_RegWrite, mem_stall);
    end
    step();
    rst_n = 1'b1;
    set_op(3'b000, 3'b000, 1'b0, 1'b1, 5'd13, 32'h00000077, 32'h0);
    dbus_rsp_valid = 1'b1; dbus_rsp_err = 1'b1; dbus_rsp_rdata = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (mem_buserr !== 1'b0 || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL late_rsp: berr %b stall %b want 0 0", mem_buserr, mem_stall);
    end
    step();
    n_checks++;
    if (W_Result !== 32'h77 || W_RegWrite !== 1'b1 || W_Rd !== 5'd13) begin
      n_fail++; $display("FAIL late_rsp_wb: %h/%b/%0d want 77/1/13", W_Result, W_RegWrite, W_Rd);
    end
    set_op(3'b001, 3'b010, 1'b0, 1'b1, 5'd14, 32'h600, 32'h0);
    mem_op(32'h0BADF00D, 1'b0, 1, 2, nv, ns, nbe, st, wd, ad, ok);
    n_checks++;
    if (!ok || W_Result !== 32'h0BADF00D || W_RegWrite !== 1'b1 || ns != 3) begin
      n_fail++; $display("FAIL post_reset_lw: %h/%b stall %0d want 0badf00d/1 3", W_Result, W_RegWrite, ns);
    end
  endtask

  initial begin
    set_nop();
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_buserr_and_alu();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
